// File: rtl/pbpix_sender.sv
// Transmit end of the pbpix rdy/ack/zero handshake: buffers upstream words in a
// small FIFO, masks them, flags all-zero words and issues exactly len pixels per pass.
module pbpix_sender #(
    parameter int DWd   = 16,
    parameter int Depth = 2,
    parameter int LenWd = 10
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_cont_start,
    input  logic [LenWd-1:0] i_cont_len,
    input  logic [DWd-1:0]   i_cont_mask,
    input  logic             i_cont_stall,
    input  logic             i_src_valid,
    input  logic [DWd-1:0]   i_src_data,
    output logic             o_src_ready,
    output logic [DWd-1:0]   o_pix,
    output logic             o_pix_rdy,
    input  logic             i_pix_ack,
    output logic             o_pix_zero,
    output logic             o_busy,
    output logic             o_done,
    output logic [LenWd-1:0] o_cnt
);

    localparam int PtrWd = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int OccWd = PtrWd + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [LenWd-1:0] acc_cnt;
    logic [DWd-1:0]   r_mask;
    logic [DWd-1:0]   fifo_data [Depth];
    logic             fifo_zero [Depth];
    logic [PtrWd-1:0] wr_ptr;
    logic [PtrWd-1:0] rd_ptr;
    logic [OccWd-1:0] occ;
    logic             full;
    logic             empty;
    logic             start_ok;
    logic             push;
    logic             pop;
    logic [DWd-1:0]   masked;

    assign full     = (occ == OccWd'(Depth));
    assign empty    = (occ == '0);
    assign masked   = i_src_data & r_mask;
    assign start_ok = (state == S_IDLE) && i_cont_start && i_cont_stall;

    // Ready deliberately ignores ack so a full FIFO never accepts, even while draining.
    assign o_src_ready = (state == S_RUN) && !full && (acc_cnt != '0) && i_cont_stall;
    assign o_pix_rdy   = !empty && i_cont_stall;
    assign push        = i_src_valid && o_src_ready;
    assign pop         = o_pix_rdy && i_pix_ack;

    assign o_pix      = empty ? '0 : fifo_data[rd_ptr];
    assign o_pix_zero = empty ? 1'b1 : fifo_zero[rd_ptr];
    assign o_busy     = (state == S_RUN);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state   <= S_IDLE;
            acc_cnt <= '0;
            o_cnt   <= '0;
            r_mask  <= '0;
            o_done  <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
        end else if (i_cont_stall) begin
            o_done <= 1'b0;

            if (start_ok) begin
                if (i_cont_len == '0) begin
                    o_done <= 1'b1;
                end else begin
                    state   <= S_RUN;
                    acc_cnt <= i_cont_len;
                    o_cnt   <= i_cont_len;
                    r_mask  <= i_cont_mask;
                end
            end

            if (push) begin
                wr_ptr  <= wr_ptr + PtrWd'(1);
                acc_cnt <= acc_cnt - LenWd'(1);
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PtrWd'(1);
                o_cnt  <= o_cnt - LenWd'(1);
                if ((state == S_RUN) && (o_cnt == LenWd'(1))) begin
                    state  <= S_IDLE;
                    o_done <= 1'b1;
                end
            end

            case ({push, pop})
                2'b10:   occ <= occ + OccWd'(1);
                2'b01:   occ <= occ - OccWd'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: the head is only visible while occupancy is nonzero.
    always_ff @(posedge i_clk) begin
        if (i_rstn && push) begin
            fifo_data[wr_ptr] <= masked;
            fifo_zero[wr_ptr] <= (masked == '0);
        end
    end

endmodule

// File: tb/tb_pbpix_sender.sv
// Randomized bench for pbpix_sender: a driver records what the consumer sees and
// each test compares it against the sequence expected from the masked source words.
module tb_pbpix_sender;

    localparam int DWd   = 16;
    localparam int Depth = 2;
    localparam int LenWd = 10;

    logic             i_clk = 1'b0;
    logic             i_rstn;
    logic             i_cont_start;
    logic [LenWd-1:0] i_cont_len;
    logic [DWd-1:0]   i_cont_mask;
    logic             i_cont_stall;
    logic             i_src_valid;
    logic [DWd-1:0]   i_src_data;
    logic             o_src_ready;
    logic [DWd-1:0]   o_pix;
    logic             o_pix_rdy;
    logic             i_pix_ack;
    logic             o_pix_zero;
    logic             o_busy;
    logic             o_done;
    logic [LenWd-1:0] o_cnt;

    always #5 i_clk = ~i_clk;

    pbpix_sender #(.DWd(DWd), .Depth(Depth), .LenWd(LenWd)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_cont_start (i_cont_start),
        .i_cont_len   (i_cont_len),
        .i_cont_mask  (i_cont_mask),
        .i_cont_stall (i_cont_stall),
        .i_src_valid  (i_src_valid),
        .i_src_data   (i_src_data),
        .o_src_ready  (o_src_ready),
        .o_pix        (o_pix),
        .o_pix_rdy    (o_pix_rdy),
        .i_pix_ack    (i_pix_ack),
        .o_pix_zero   (o_pix_zero),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_cnt        (o_cnt)
    );

    int errors = 0;
    int checks = 0;

    logic [DWd-1:0] src_q[$];
    logic [DWd-1:0] got_q[$];
    logic           got_zero_q[$];
    int             cnt_q[$];
    int             done_cnt, done_cyc, last_xfer_cyc, accepts;
    int             acc_at_release;
    logic           ready_at_release;
    logic           stall_rdy_any, stall_ready_any, stall_cnt_moved, rdy_resume;
    int             cnt_stall_start, xfers_before_stall, cnt_resume;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_pass(input int len, input logic [DWd-1:0] mask);
        i_cont_len   = LenWd'(len);
        i_cont_mask  = mask;
        i_cont_start = 1'b1;
        tick();
        i_cont_start = 1'b0;
    endtask

    // Drives source/consumer for up to max_cyc cycles and records observations only.
    task automatic pump(input int max_cyc, input int valid_pct, input int ack_pct,
                        input int hold_ack, input int stall_from, input int stall_len,
                        input int inject_cnt);
        bit injected = 1'b0;
        got_q.delete(); got_zero_q.delete(); cnt_q.delete();
        done_cnt = 0; done_cyc = -1; last_xfer_cyc = -2; accepts = 0;
        acc_at_release = -1; ready_at_release = 1'b1;
        stall_rdy_any = 1'b0; stall_ready_any = 1'b0; stall_cnt_moved = 1'b0;
        rdy_resume = 1'b0; cnt_stall_start = -1; xfers_before_stall = -1; cnt_resume = -1;
        for (int c = 0; c < max_cyc; c++) begin
            i_cont_stall = !(stall_len > 0 && c >= stall_from && c < stall_from + stall_len);
            i_src_valid  = (src_q.size() > 0) && ($urandom_range(99) < valid_pct);
            i_src_data   = (src_q.size() > 0) ? src_q[0] : '0;
            i_pix_ack    = (c < hold_ack) ? 1'b0 : ($urandom_range(99) < ack_pct);
            if (inject_cnt >= 0 && !injected && int'(o_cnt) == inject_cnt) begin
                i_cont_start = 1'b1;
                i_cont_len   = LenWd'(3);
                injected     = 1'b1;
            end else begin
                i_cont_start = 1'b0;
            end
            #1;
            if (hold_ack > 0 && c == hold_ack) begin
                acc_at_release   = accepts;
                ready_at_release = o_src_ready;
            end
            if (stall_len > 0) begin
                if (c == stall_from) begin
                    cnt_stall_start    = int'(o_cnt);
                    xfers_before_stall = got_q.size();
                end
                if (!i_cont_stall) begin
                    stall_rdy_any   |= o_pix_rdy;
                    stall_ready_any |= o_src_ready;
                    if (int'(o_cnt) != cnt_stall_start) stall_cnt_moved = 1'b1;
                end
                if (c == stall_from + stall_len) begin
                    cnt_resume = int'(o_cnt);
                    rdy_resume = o_pix_rdy;
                end
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (i_src_valid && o_src_ready) begin
                void'(src_q.pop_front());
                accepts++;
            end
            if (o_pix_rdy && i_pix_ack) begin
                got_q.push_back(o_pix);
                got_zero_q.push_back(o_pix_zero);
                cnt_q.push_back(int'(o_cnt));
                last_xfer_cyc = c;
            end
            if (done_cnt > 0 && c >= done_cyc + 2) break;
            @(posedge i_clk);
            #1;
        end
        i_cont_start = 1'b0;
        i_src_valid  = 1'b0;
        i_pix_ack    = 1'b0;
        i_cont_stall = 1'b1;
    endtask

    task automatic test_reset();
        i_rstn = 1'b0; i_cont_start = 1'b0; i_cont_len = '0; i_cont_mask = '0;
        i_cont_stall = 1'b1; i_src_valid = 1'b0; i_src_data = '0; i_pix_ack = 1'b0;
        tick(); tick();
        checks++; if (o_pix !== '0) begin errors++; $display("FAIL reset_pix: got %0h, expected 0", o_pix); end
        checks++; if (o_pix_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %0b, expected 0", o_pix_rdy); end
        checks++; if (o_pix_zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %0b, expected 1", o_pix_zero); end
        checks++; if (o_src_ready !== 1'b0) begin errors++; $display("FAIL reset_src_ready: got %0b, expected 0", o_src_ready); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, expected 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b, expected 0", o_done); end
        checks++; if (o_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d, expected 0", o_cnt); end
        i_rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic_pass();
        logic [DWd-1:0] exp_q[$];
        exp_q = '{16'd1, 16'd2, 16'd0, 16'd3};
        src_q = exp_q;
        start_pass(4, 16'hFFFF);
        pump(60, 100, 100, 0, 0, 0, -1);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d, expected 4", got_q.size()); end
        for (int k = 0; k < got_q.size() && k < 4; k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL basic_pix[%0d]: got %0h, expected %0h", k, got_q[k], exp_q[k]); end
            checks++; if (got_zero_q[k] !== (k == 2)) begin errors++; $display("FAIL basic_zero[%0d]: got %0b, expected %0b", k, got_zero_q[k], k == 2); end
            checks++; if (cnt_q[k] != 4 - k) begin errors++; $display("FAIL basic_cnt[%0d]: got %0d, expected %0d", k, cnt_q[k], 4 - k); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d, expected 1", done_cnt); end
        checks++; if (done_cyc != last_xfer_cyc + 1) begin errors++; $display("FAIL basic_done_cycle: got %0d, expected %0d", done_cyc, last_xfer_cyc + 1); end
        checks++; if (o_cnt !== '0) begin errors++; $display("FAIL basic_cnt_end: got %0d, expected 0", o_cnt); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %0b, expected 0", o_busy); end
    endtask

    task automatic test_mask();
        src_q = '{16'hAB00, 16'hAB01};
        start_pass(2, 16'h00FF);
        pump(60, 100, 100, 0, 0, 0, -1);
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL mask_count: got %0d, expected 2", got_q.size()); end
        if (got_q.size() == 2) begin
            checks++; if (got_q[0] !== 16'h0000) begin errors++; $display("FAIL mask_pix0: got %0h, expected 0", got_q[0]); end
            checks++; if (got_zero_q[0] !== 1'b1) begin errors++; $display("FAIL mask_zero0: got %0b, expected 1", got_zero_q[0]); end
            checks++; if (got_q[1] !== 16'h0001) begin errors++; $display("FAIL mask_pix1: got %0h, expected 1", got_q[1]); end
            checks++; if (got_zero_q[1] !== 1'b0) begin errors++; $display("FAIL mask_zero1: got %0b, expected 0", got_zero_q[1]); end
        end
    endtask

    task automatic test_backpressure();
        logic [DWd-1:0] exp_q[$];
        for (int k = 0; k < 5; k++) exp_q.push_back(DWd'($urandom_range(1, 16'hFFFF)));
        src_q = exp_q;
        start_pass(5, 16'hFFFF);
        pump(80, 100, 100, 6, 0, 0, -1);
        checks++; if (acc_at_release != Depth) begin errors++; $display("FAIL bp_accepts_full: got %0d, expected %0d", acc_at_release, Depth); end
        checks++; if (ready_at_release !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %0b, expected 0", ready_at_release); end
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL bp_count: got %0d, expected 5", got_q.size()); end
        for (int k = 0; k < got_q.size() && k < 5; k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL bp_pix[%0d]: got %0h, expected %0h", k, got_q[k], exp_q[k]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_stall();
        logic [DWd-1:0] exp_q[$];
        for (int k = 0; k < 8; k++) exp_q.push_back(DWd'($urandom));
        src_q = exp_q;
        start_pass(8, 16'hFFFF);
        pump(80, 100, 100, 0, 3, 3, -1);
        checks++; if (stall_rdy_any !== 1'b0) begin errors++; $display("FAIL stall_rdy: got %0b, expected 0", stall_rdy_any); end
        checks++; if (stall_ready_any !== 1'b0) begin errors++; $display("FAIL stall_src_ready: got %0b, expected 0", stall_ready_any); end
        checks++; if (stall_cnt_moved !== 1'b0) begin errors++; $display("FAIL stall_cnt_moved: got %0b, expected 0", stall_cnt_moved); end
        checks++; if (cnt_stall_start != 8 - xfers_before_stall) begin errors++; $display("FAIL stall_cnt: got %0d, expected %0d", cnt_stall_start, 8 - xfers_before_stall); end
        checks++; if (cnt_resume != cnt_stall_start) begin errors++; $display("FAIL stall_cnt_resume: got %0d, expected %0d", cnt_resume, cnt_stall_start); end
        checks++; if (rdy_resume !== 1'b1) begin errors++; $display("FAIL stall_resume_rdy: got %0b, expected 1", rdy_resume); end
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL stall_count: got %0d, expected 8", got_q.size()); end
        for (int k = 0; k < got_q.size() && k < 8; k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL stall_pix[%0d]: got %0h, expected %0h", k, got_q[k], exp_q[k]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done_count: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_start_rules();
        start_pass(0, 16'hFFFF);
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL len0_done: got %0b, expected 1", o_done); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %0b, expected 0", o_busy); end
        tick();
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL len0_done_clear: got %0b, expected 0", o_done); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL len0_busy_after: got %0b, expected 0", o_busy); end
        src_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        start_pass(4, 16'hFFFF);
        pump(60, 100, 100, 0, 0, 0, 2);
        checks++; if (cnt_q.size() != 4) begin errors++; $display("FAIL run_start_count: got %0d, expected 4", cnt_q.size()); end
        for (int k = 0; k < cnt_q.size() && k < 4; k++) begin
            checks++; if (cnt_q[k] != 4 - k) begin errors++; $display("FAIL run_start_cnt[%0d]: got %0d, expected %0d", k, cnt_q[k], 4 - k); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL run_start_done: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_random_passes();
        logic [DWd-1:0] exp_q[$];
        logic [DWd-1:0] mask;
        logic [DWd-1:0] w;
        int len;
        for (int p = 0; p < 4; p++) begin
            len  = $urandom_range(1, 12);
            mask = DWd'($urandom);
            exp_q.delete();
            src_q.delete();
            for (int k = 0; k < len + 2; k++) begin
                w = ($urandom_range(3) == 0) ? ~mask : DWd'($urandom);
                src_q.push_back(w);
                if (k < len) exp_q.push_back(w & mask);
            end
            start_pass(len, mask);
            pump(400, 70, 60, 0, 0, 0, -1);
            checks++; if (got_q.size() != len) begin errors++; $display("FAIL rnd%0d_count: got %0d, expected %0d", p, got_q.size(), len); end
            for (int k = 0; k < got_q.size() && k < len; k++) begin
                checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rnd%0d_pix[%0d]: got %0h, expected %0h", p, k, got_q[k], exp_q[k]); end
                checks++; if (got_zero_q[k] !== (exp_q[k] == '0)) begin errors++; $display("FAIL rnd%0d_zero[%0d]: got %0b, expected %0b", p, k, got_zero_q[k], exp_q[k] == '0); end
                checks++; if (cnt_q[k] != len - k) begin errors++; $display("FAIL rnd%0d_cnt[%0d]: got %0d, expected %0d", p, k, cnt_q[k], len - k); end
            end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL rnd%0d_done_count: got %0d, expected 1", p, done_cnt); end
            checks++; if (done_cyc != last_xfer_cyc + 1) begin errors++; $display("FAIL rnd%0d_done_cycle: got %0d, expected %0d", p, done_cyc, last_xfer_cyc + 1); end
            checks++; if (src_q.size() != 2) begin errors++; $display("FAIL rnd%0d_excess_taken: got %0d left, expected 2", p, src_q.size()); end
            checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy_end: got %0b, expected 0", p, o_busy); end
        end
    endtask

    task automatic test_reset_mid_pass();
        int done_seen = 0;
        start_pass(6, 16'hFFFF);
        i_pix_ack   = 1'b0;
        i_src_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_src_data = DWd'(k + 1);
            tick();
        end
        i_src_valid = 1'b0;
        checks++; if (o_pix_rdy !== 1'b1 || o_pix !== 16'd1) begin errors++; $display("FAIL rstmid_buffered: got rdy=%0b pix=%0h, expected rdy=1 pix=1", o_pix_rdy, o_pix); end
        i_rstn = 1'b0;
        tick();
        checks++; if (o_pix_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_rdy: got %0b, expected 0", o_pix_rdy); end
        checks++; if (o_pix_zero !== 1'b1) begin errors++; $display("FAIL rstmid_zero: got %0b, expected 1", o_pix_zero); end
        checks++; if (o_cnt !== '0) begin errors++; $display("FAIL rstmid_cnt: got %0d, expected 0", o_cnt); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b, expected 0", o_busy); end
        checks++; if (o_src_ready !== 1'b0) begin errors++; $display("FAIL rstmid_src_ready: got %0b, expected 0", o_src_ready); end
        i_rstn    = 1'b1;
        i_pix_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (o_done) done_seen++;
            tick();
        end
        i_pix_ack = 1'b0;
        checks++; if (done_seen != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses, expected 0", done_seen); end
        checks++; if (o_pix_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_stays_empty: got %0b, expected 0", o_pix_rdy); end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_mask();
        test_backpressure();
        test_stall();
        test_start_rules();
        test_random_passes();
        test_reset_mid_pass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
